// File: rtl/data_logger_pkg.sv
// Shared types and defaults for the data logger page buffer.
package data_logger_pkg;

  // Default geometry: one EEPROM page of 64 bytes per bank
  localparam int DEFAULT_SAMPLE_W   = 8;
  localparam int DEFAULT_PAGE_DEPTH = 64;

  // Width of the optional saturating dropped-sample counter
  localparam int DROP_CNT_W = 16;

  // Lifecycle of each ping-pong bank
  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  // Read-side sequencer: waiting for a closed page, or streaming one out
  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_t;

endpackage

// File: rtl/page_bank_ram.sv
// Simple dual-port RAM holding both banks, addressed as {bank, idx}.
// One write port, one registered read port with a read enable so the
// output word holds while the consumer stalls.
module page_bank_ram #(
  parameter int  SAMPLE_W   = 8,
  parameter int  PAGE_DEPTH = 64,
  localparam int ADDR_W     = $clog2(PAGE_DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [SAMPLE_W-1:0] i_wdata,
  input  logic                i_re,
  input  logic [ADDR_W-1:0]   i_raddr,
  output logic [SAMPLE_W-1:0] o_rdata
);

  logic [SAMPLE_W-1:0] r_mem [2**ADDR_W];

  // Storage array: written on demand, never cleared
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; reset clears only the output word
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/sample_page_buffer.sv
// Ping-pong page buffer between ADC sampler and EEPROM writer.
// Optional feature macro: SAMPLE_PAGE_DROP_CNT_EN adds a saturating
// 16-bit drop_count output next to the sticky overflow flag.
module sample_page_buffer
  import data_logger_pkg::*;
#(
  parameter int  SAMPLE_W   = DEFAULT_SAMPLE_W,
  parameter int  PAGE_DEPTH = DEFAULT_PAGE_DEPTH,
  localparam int IDX_W      = $clog2(PAGE_DEPTH),
  localparam int LEN_W      = $clog2(PAGE_DEPTH + 1)
) (
  input  logic                CLK_50MHz,
  input  logic                RESET,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] Sample_word,
  input  logic                flush,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_last,
  output logic [LEN_W-1:0]    page_len,
  output logic                overflow,
  output logic                wr_bank
`ifdef SAMPLE_PAGE_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_count
`endif
);

  rd_state_t         r_rdState, w_rdStateNext;
  logic              r_rdBank, w_rdBankNext;
  logic [IDX_W-1:0]  r_rdIdx, w_rdIdxNext;
  logic              w_ramRe;
  logic [IDX_W:0]    w_ramRaddr;
  logic              w_rdStart, w_rdStartBank;
  logic              w_accept, w_rdLastInt, w_release;
  logic [LEN_W-1:0]  w_curLen;

  bank_state_t       r_bankState [2];
  bank_state_t       w_bankStateNext [2];
  logic [LEN_W-1:0]  r_bankLen [2];
  logic [LEN_W-1:0]  w_bankLenNext [2];

  logic              r_wrBank, w_wrBankNext;
  logic [IDX_W-1:0]  r_wrIdx, w_wrIdxNext;
  logic              w_wrOpen, w_write, w_writeLast, w_flushClose, w_drop;
  logic              r_overflow;

  assign w_curLen    = r_bankLen[r_rdBank];
  assign rd_valid    = (r_rdState == RD_STREAM);
  assign w_rdLastInt = rd_valid && ((LEN_W'(r_rdIdx) + LEN_W'(1)) == w_curLen);
  assign w_accept    = rd_valid && rd_ready;
  assign w_release   = w_accept && w_rdLastInt;
  assign rd_last     = w_rdLastInt;
  assign page_len    = rd_valid ? w_curLen : '0;
  assign overflow    = r_overflow;
  assign wr_bank     = r_wrBank;

  page_bank_ram #(
    .SAMPLE_W   (SAMPLE_W),
    .PAGE_DEPTH (PAGE_DEPTH)
  ) u_ram (
    .i_clk   (CLK_50MHz),
    .i_reset (RESET),
    .i_we    (w_write),
    .i_waddr ({r_wrBank, r_wrIdx}),
    .i_wdata (Sample_word),
    .i_re    (w_ramRe),
    .i_raddr (w_ramRaddr),
    .o_rdata (rd_data)
  );

  // Read sequencer: prefetch word 0 of the next closed page, then advance one word per accepted transfer; chain straight into the other bank when it is already closed
  always_comb begin
    w_rdStateNext = r_rdState;
    w_rdBankNext  = r_rdBank;
    w_rdIdxNext   = r_rdIdx;
    w_ramRe       = 1'b0;
    w_ramRaddr    = {r_rdBank, r_rdIdx};
    w_rdStart     = 1'b0;
    w_rdStartBank = r_rdBank;
    case (r_rdState)
      RD_IDLE: begin
        if (r_bankState[r_rdBank] == BANK_FULL) begin
          w_ramRe       = 1'b1;
          w_ramRaddr    = {r_rdBank, {IDX_W{1'b0}}};
          w_rdIdxNext   = '0;
          w_rdStart     = 1'b1;
          w_rdStateNext = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (w_accept) begin
          if (w_rdLastInt) begin
            w_rdBankNext = ~r_rdBank;
            w_rdIdxNext  = '0;
            if (r_bankState[~r_rdBank] == BANK_FULL) begin
              w_ramRe       = 1'b1;
              w_ramRaddr    = {~r_rdBank, {IDX_W{1'b0}}};
              w_rdStart     = 1'b1;
              w_rdStartBank = ~r_rdBank;
            end else begin
              w_rdStateNext = RD_IDLE;
            end
          end else begin
            w_ramRe     = 1'b1;
            w_ramRaddr  = {r_rdBank, r_rdIdx + IDX_W'(1)};
            w_rdIdxNext = r_rdIdx + IDX_W'(1);
          end
        end
      end
      default: w_rdStateNext = RD_IDLE;
    endcase
  end

  // Bank bookkeeping and write side: read-side release is applied first so a sample landing on a just-freed bank is kept
  always_comb begin
    w_bankStateNext = r_bankState;
    w_bankLenNext   = r_bankLen;
    w_wrBankNext    = r_wrBank;
    w_wrIdxNext     = r_wrIdx;
    if (w_release) begin
      w_bankStateNext[r_rdBank] = BANK_EMPTY;
    end
    if (w_rdStart) begin
      w_bankStateNext[w_rdStartBank] = BANK_DRAINING;
    end
    w_wrOpen     = (w_bankStateNext[r_wrBank] == BANK_EMPTY) ||
                   (w_bankStateNext[r_wrBank] == BANK_FILLING);
    w_write      = sample_valid && w_wrOpen;
    w_drop       = sample_valid && !w_wrOpen;
    w_writeLast  = w_write && (r_wrIdx == IDX_W'(PAGE_DEPTH - 1));
    w_flushClose = flush && !w_writeLast && ((r_wrIdx != '0) || w_write);
    if (w_writeLast) begin
      w_bankStateNext[r_wrBank] = BANK_FULL;
      w_bankLenNext[r_wrBank]   = LEN_W'(PAGE_DEPTH);
      w_wrBankNext              = ~r_wrBank;
      w_wrIdxNext               = '0;
    end else if (w_flushClose) begin
      w_bankStateNext[r_wrBank] = BANK_FULL;
      w_bankLenNext[r_wrBank]   = LEN_W'(r_wrIdx) + (w_write ? LEN_W'(1) : LEN_W'(0));
      w_wrBankNext              = ~r_wrBank;
      w_wrIdxNext               = '0;
    end else if (w_write) begin
      w_bankStateNext[r_wrBank] = BANK_FILLING;
      w_wrIdxNext               = r_wrIdx + IDX_W'(1);
    end
  end

  // State register for both sides; reset discards any in-flight pages
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      r_rdState      <= RD_IDLE;
      r_rdBank       <= 1'b0;
      r_rdIdx        <= '0;
      r_bankState[0] <= BANK_EMPTY;
      r_bankState[1] <= BANK_EMPTY;
      r_bankLen[0]   <= '0;
      r_bankLen[1]   <= '0;
      r_wrBank       <= 1'b0;
      r_wrIdx        <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_rdState   <= w_rdStateNext;
      r_rdBank    <= w_rdBankNext;
      r_rdIdx     <= w_rdIdxNext;
      r_bankState <= w_bankStateNext;
      r_bankLen   <= w_bankLenNext;
      r_wrBank    <= w_wrBankNext;
      r_wrIdx     <= w_wrIdxNext;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef SAMPLE_PAGE_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_dropCount;
  assign drop_count = r_dropCount;

  // Saturating count of dropped samples
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      r_dropCount <= '0;
    end else if (w_drop && (r_dropCount != {DROP_CNT_W{1'b1}})) begin
      r_dropCount <= r_dropCount + DROP_CNT_W'(1);
    end
  end
`endif

endmodule
